// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped data cache: FSM states and the line record.
// Line tag field is sized for the smallest legal index (SETS=2) so any legal SETS fits.
package dcache_pkg;

  localparam int unsigned DC_ADDR_W    = 32;
  localparam int unsigned DC_DATA_W    = 32;
  localparam int unsigned DC_SETS      = 8;
  localparam int unsigned DC_TAG_MAX_W = DC_ADDR_W - 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } dc_state_e;

  typedef struct packed {
    logic                    valid;
    logic [DC_TAG_MAX_W-1:0] tag;
    logic [DC_DATA_W-1:0]    data;
  } dc_line_t;

endpackage

// File: rtl/dcache_line_array.sv
// Tag/data/valid storage: asynchronous read, one synchronous write port,
// valid bits cleared by the asynchronous reset (tag/data are never reset).
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned SETS  = DC_SETS,
  parameter int unsigned IDX_W = $clog2(SETS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_ridx,
  output dc_line_t         o_rline,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  dc_line_t         i_wline
);

  logic [SETS-1:0]         r_valid;
  logic [DC_TAG_MAX_W-1:0] r_tag  [SETS];
  logic [DC_DATA_W-1:0]    r_data [SETS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= i_wline.valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wline.tag;
      r_data[i_widx] <= i_wline.data;
    end
  end

  always_comb begin
    o_rline       = '0;
    o_rline.valid = r_valid[i_ridx];
    o_rline.tag   = r_tag[i_ridx];
    o_rline.data  = r_data[i_ridx];
  end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, one-word-line, write-through/no-write-allocate data cache.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_direct_mapped
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = DC_ADDR_W,
  parameter int unsigned DATA_W = DC_DATA_W,
  parameter int unsigned SETS   = DC_SETS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);

  dc_state_e         r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [IDX_W-1:0]        w_idx;
  logic [DC_TAG_MAX_W-1:0] w_tag;
  logic [ADDR_W-1:0]       w_word_addr;
  dc_line_t                w_rline;
  dc_line_t                w_wline;
  logic                    w_line_we;
  logic                    w_hit;
  logic                    w_ready;
  logic                    w_unused_addr;

  assign w_idx         = addr_i[IDX_W+1:2];
  assign w_tag         = DC_TAG_MAX_W'(addr_i[ADDR_W-1:IDX_W+2]);
  assign w_word_addr   = {addr_i[ADDR_W-1:2], 2'b00};
  assign w_unused_addr = &{1'b0, addr_i[1:0]};
  assign w_hit         = w_rline.valid && (w_rline.tag == w_tag);

  dcache_line_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W)
  ) u_lines (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_ridx  (w_idx),
    .o_rline (w_rline),
    .i_we    (w_line_we),
    .i_widx  (w_idx),
    .i_wline (w_wline)
  );

  // Refill always allocates; a store only touches the line when it already hits.
  always_comb begin
    w_line_we     = mem_ack_i && ((r_state == ST_REFILL) || ((r_state == ST_WRITE) && w_hit));
    w_wline       = '0;
    w_wline.valid = 1'b1;
    w_wline.tag   = w_tag;
    w_wline.data  = (r_state == ST_REFILL) ? mem_rdata_i : wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i && we_i) begin
            r_state     <= ST_WRITE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_word_addr;
            r_mem_wdata <= wdata_i;
          end else if (req_i && !w_hit) begin
            r_state    <= ST_REFILL;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_word_addr;
          end
        end
        ST_REFILL, ST_WRITE: begin
          if (mem_ack_i) begin
            r_state   <= ST_RESP;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_ready     = (r_state == ST_RESP) ||
                       ((r_state == ST_IDLE) && req_i && !we_i && w_hit);
  assign ready_o     = w_ready;
  assign rdata_o     = (w_ready && !we_i) ? w_rline.data : '0;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

`ifdef DCACHE_STATS_EN
  logic        w_cnt_hit;
  logic        w_cnt_miss;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Reads count at ready (hit in IDLE, miss in RESP); writes count in RESP by line state.
  assign w_cnt_hit  = w_ready && (we_i ? w_hit : (r_state == ST_IDLE));
  assign w_cnt_miss = w_ready && !w_cnt_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_cnt_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_cnt_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
